fetch_sequencer: RTL and testbench

//  Program-counter and run-control sequencer in front of the 9-bit instruction ROM.

---
 rtl/fetch_pkg.sv | 7 +
 rtl/fetch_sequencer_sat_counter.sv | 20 ++
 rtl/fetch_sequencer.sv | 85 ++++++++
 tb/tb_fetch_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch sequencer.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} fetch_state_t;
  localparam int A_DEF  = 10;
  localparam int OW_DEF = 6;
  localparam int CW_DEF = 16;
endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         cnt_q <= '0;
    else if (clr_i)                     cnt_q <= '0;
    else if (inc_i && (cnt_q != '1))    cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/fetch_sequencer.sv
// PC and Start/Ack run control for the instruction ROM: applies halt, stall
// and branch requests, flags PC wrap, and counts RUN cycles.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int A  = A_DEF,
  parameter int OW = OW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [A-1:0]  StartAddr,
  input  logic          Stall,
  input  logic          Halt,
  input  logic          BranchAbs,
  input  logic [A-1:0]  Target,
  input  logic          BranchRel,
  input  logic [OW-1:0] Offset,
  output logic [A-1:0]  ProgCtr,
  output logic          InstValid,
  output logic          Ack,
  output logic          WrapErr,
  output logic [CW-1:0] CycleCount
);
  fetch_state_t state_q;
  logic [A-1:0] pc_q;
  logic         ack_q, wrap_q;
  logic [A:0]   step, sum;
  logic         load_req;

  // One extra bit on the adder: bit A of the sum flags carry-out or borrow.
  always_comb begin
    step = BranchRel ? {{(A+1-OW){Offset[OW-1]}}, Offset} : (A+1)'(1);
    sum  = {1'b0, pc_q} + step;
  end

  // StartAddr is captured on every edge Start is high outside RUN.
  assign load_req = Start && (state_q != RUN);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ack_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (load_req) begin
      state_q <= LOAD;
      pc_q    <= StartAddr;
      ack_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      case (state_q)
        LOAD: state_q <= RUN;
        RUN: begin
          if (Start)          state_q <= LOAD;
          else if (Stall)     ;
          else if (Halt) begin
            state_q <= DONE;
            ack_q   <= 1'b1;
          end
          else if (BranchAbs) pc_q <= Target;
          else begin
            pc_q <= sum[A-1:0];
            if (sum[A]) wrap_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.W(CW)) u_cycles (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr_i (load_req),
    .inc_i (state_q == RUN),
    .cnt_o (CycleCount)
  );

  assign ProgCtr   = pc_q;
  assign InstValid = (state_q == RUN);
  assign Ack       = ack_q;
  assign WrapErr   = wrap_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Random and directed stimulus against a cycle-level reference model; a
// second instance with a 4-bit counter exercises saturation.
module tb_fetch_sequencer;
  localparam int A = 10, OW = 6, CW = 16, CW4 = 4;
  localparam int DEPTH = 1 << A;

  logic Clk = 1'b0, Reset_n = 1'b0, Start = 1'b0, Stall = 1'b0, Halt = 1'b0;
  logic BranchAbs = 1'b0, BranchRel = 1'b0;
  logic [A-1:0]  StartAddr = '0, Target = '0;
  logic [OW-1:0] Offset = '0;

  logic [A-1:0]   pc_a, pc_b;
  logic           iv_a, iv_b, ack_a, ack_b, wr_a, wr_b;
  logic [CW-1:0]  cnt_a;
  logic [CW4-1:0] cnt_b;

  fetch_sequencer #(.A(A), .OW(OW), .CW(CW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
    .Stall(Stall), .Halt(Halt), .BranchAbs(BranchAbs), .Target(Target),
    .BranchRel(BranchRel), .Offset(Offset), .ProgCtr(pc_a), .InstValid(iv_a),
    .Ack(ack_a), .WrapErr(wr_a), .CycleCount(cnt_a));

  fetch_sequencer #(.A(A), .OW(OW), .CW(CW4)) dut4 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
    .Stall(Stall), .Halt(Halt), .BranchAbs(BranchAbs), .Target(Target),
    .BranchRel(BranchRel), .Offset(Offset), .ProgCtr(pc_b), .InstValid(iv_b),
    .Ack(ack_b), .WrapErr(wr_b), .CycleCount(cnt_b));

  always #5 Clk = ~Clk;

  int checks = 0, errors = 0;

  // Reference model: run phase as flags, PC as an integer, count unbounded.
  bit m_loading, m_running, m_finished;
  int m_pc, m_cnt;
  bit m_ack, m_wrap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_loading = 0; m_running = 0; m_finished = 0;
    m_pc = 0; m_cnt = 0; m_ack = 0; m_wrap = 0;
  endtask

  task automatic m_edge();
    int nxt, off;
    if (m_running) begin
      m_cnt++;
      if (Start) begin m_running = 0; m_loading = 1; end
      else if (Stall) ;
      else if (Halt) begin m_running = 0; m_finished = 1; m_ack = 1; end
      else begin
        off = $signed(Offset);
        if (BranchAbs)      nxt = int'(Target);
        else if (BranchRel) nxt = m_pc + off;
        else                nxt = m_pc + 1;
        if (nxt < 0 || nxt >= DEPTH) m_wrap = 1;
        m_pc = (nxt + DEPTH) % DEPTH;
      end
    end else if (Start) begin
      m_loading = 1; m_finished = 0;
      m_pc = int'(StartAddr); m_cnt = 0; m_wrap = 0; m_ack = 0;
    end else if (m_loading) begin
      m_loading = 0; m_running = 1;
    end
  endtask

  task automatic check_all(input string tag);
    int c16, c4;
    c16 = (m_cnt > 65535) ? 65535 : m_cnt;
    c4  = (m_cnt > 15) ? 15 : m_cnt;
    chk({tag, ".pc"},   32'(pc_a),  32'(m_pc));
    chk({tag, ".iv"},   32'(iv_a),  32'(m_running));
    chk({tag, ".ack"},  32'(ack_a), 32'(m_ack));
    chk({tag, ".wrap"}, 32'(wr_a),  32'(m_wrap));
    chk({tag, ".cnt"},  32'(cnt_a), 32'(c16));
    chk({tag, ".cnt4"}, 32'(cnt_b), 32'(c4));
    chk({tag, ".pc4"},  32'(pc_b),  32'(m_pc));
  endtask

  task automatic cyc(input string tag);
    @(posedge Clk);
    m_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_in();
    Start = 0; Stall = 0; Halt = 0; BranchAbs = 0; BranchRel = 0;
  endtask

  task automatic load(input logic [A-1:0] addr);
    idle_in();
    Start = 1; StartAddr = addr;
    repeat (3) cyc("load");
    Start = 0;
    cyc("go");
  endtask

  initial begin
    m_reset();
    #1;
    check_all("reset");
    repeat (2) @(negedge Clk);
    Reset_n = 1;

    // Plain sequential fetch
    load(10'h010);
    chk("seq.first", 32'(pc_a), 32'h010);
    chk("seq.iv", 32'(iv_a), 32'h1);
    cyc("seq"); chk("seq.pc1", 32'(pc_a), 32'h011);
    cyc("seq"); chk("seq.pc2", 32'(pc_a), 32'h012);

    // Stall overrides Halt, then Halt completes
    load(10'h020);
    Stall = 1; Halt = 1;
    cyc("stall"); cyc("stall");
    chk("stall.pc", 32'(pc_a), 32'h020);
    chk("stall.ack", 32'(ack_a), 32'h0);
    Stall = 0;
    cyc("halt");
    chk("halt.ack", 32'(ack_a), 32'h1);
    Halt = 0;
    cyc("done");
    chk("done.frozen", 32'(pc_a), 32'h020);

    // Restart from DONE: ack drops on the first Start edge
    Start = 1; StartAddr = 10'h030;
    cyc("restart");
    chk("restart.ack", 32'(ack_a), 32'h0);
    chk("restart.pc", 32'(pc_a), 32'h030);
    chk("restart.cnt", 32'(cnt_a), 32'h0);
    load(10'h030);
    BranchAbs = 1; Target = 10'h100; BranchRel = 1; Offset = 6'h3C;
    cyc("absrel");
    chk("absrel.pc", 32'(pc_a), 32'h100);
    idle_in();

    // Wrap in both directions
    load(10'h3FE);
    cyc("wrapup"); cyc("wrapup");
    chk("wrapup.pc", 32'(pc_a), 32'h000);
    chk("wrapup.err", 32'(wr_a), 32'h1);
    load(10'h002);
    chk("wrapclr", 32'(wr_a), 32'h0);
    BranchRel = 1; Offset = 6'h3C;
    cyc("wrapdn");
    chk("wrapdn.pc", 32'(pc_a), 32'h3FE);
    chk("wrapdn.err", 32'(wr_a), 32'h1);
    Offset = 6'h00;
    cyc("selfloop");
    chk("selfloop.pc", 32'(pc_a), 32'h3FE);
    idle_in();

    // Saturation of the narrow counter, then async reset mid-run
    load(10'h000);
    repeat (20) cyc("sat");
    chk("sat.cnt4", 32'(cnt_b), 32'hF);
    Reset_n = 0;
    #1;
    m_reset();
    check_all("areset");
    @(negedge Clk);
    Reset_n = 1;

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      Start     = ($urandom_range(99) < 4);
      StartAddr = A'($urandom);
      Stall     = ($urandom_range(99) < 20);
      Halt      = ($urandom_range(99) < 5);
      BranchAbs = ($urandom_range(99) < 10);
      Target    = A'($urandom);
      BranchRel = ($urandom_range(99) < 20);
      Offset    = OW'($urandom);
      cyc("rnd");
      if (m_finished && ($urandom_range(9) < 3)) begin
        idle_in(); Start = 1; StartAddr = A'($urandom);
        cyc("rnd.rst");
      end
      if ($urandom_range(999) < 5) begin
        Reset_n = 0;
        #2;
        m_reset();
        check_all("rnd.areset");
        @(negedge Clk);
        Reset_n = 1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
